// File: rtl/rotary_pkg.sv
// Shared constants for the quadrature encoder front-end: FSM encodings, detent phase,
// accumulator limit and the default debounce length.
package rotary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  localparam logic [1:0] PH_DETENT = 2'b11;

  // The accumulator spans -4..+4, which needs a 4-bit signed register.
  localparam logic signed [3:0] ACC_FULL = 4'sd4;

  localparam logic [15:0] FILTER_CYCLES_DEF = 16'd5000;

  // Position of a phase code along the clockwise sequence 11 -> 01 -> 00 -> 10.
  function automatic logic [1:0] phase_index(input logic [1:0] ph);
    logic [1:0] idx;
    case (ph)
      2'b11:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b00:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/contact_filter.sv
// One encoder contact: 2-flop synchroniser followed by a debounce counter that only
// lets the filtered value follow after FILTER_CYCLES consecutive differing samples.
module contact_filter
  import rotary_pkg::*;
#(
  parameter int                  FILTER_W      = 16,
  parameter logic [FILTER_W-1:0] FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic CLK,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam logic [FILTER_W-1:0] CNT_LAST = FILTER_CYCLES - FILTER_W'(1);

  logic                sync1_reg;
  logic                sync2_reg;
  logic                filt_reg;
  logic [FILTER_W-1:0] cnt_reg;

  // Contacts are pulled up, so the idle level is 1 throughout the chain.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      filt_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        filt_reg <= sync2_reg;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + FILTER_W'(1);
      end
    end
  end

  assign filtered = filt_reg;

endmodule

// File: rtl/rotary_decoder.sv
// Quadrature decoder: filters A/B, tracks phase steps in a saturating
// accumulator and emits one rotary_event per full detent. Define ROTARY_ERR_CNT_EN
// to expose err_count, a saturating count of invalid double-bit phase changes.
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int                  FILTER_W      = 16,
  parameter logic [FILTER_W-1:0] FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rotary_a,
  input  logic       rotary_b,
  output logic       rotary_event,
  output logic       rotary_right
`ifdef ROTARY_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  logic [1:0] raw_ab;
  logic [1:0] phase;

  assign raw_ab = {rotary_a, rotary_b};

  // Bit 1 is contact A, bit 0 is contact B, so phase = {A_f, B_f}.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filter
      contact_filter #(
        .FILTER_W      (FILTER_W),
        .FILTER_CYCLES (FILTER_CYCLES)
      ) u_filter (
        .CLK      (CLK),
        .reset    (reset),
        .raw      (raw_ab[gi]),
        .filtered (phase[gi])
      );
    end
  endgenerate

  state_t            state_reg;
  logic        [1:0] phase_prev_reg;
  logic signed [3:0] acc_reg;
  logic              event_reg;
  logic              right_reg;

  logic [1:0]        idx_prev;
  logic [1:0]        idx_cur;
  logic              step_cw;
  logic              step_ccw;
  logic              step_bad;
  logic signed [3:0] acc_next;

  always_comb begin
    idx_prev = phase_index(phase_prev_reg);
    idx_cur  = phase_index(phase);
    step_cw  = (idx_cur == idx_prev + 2'd1);
    step_ccw = (idx_cur == idx_prev - 2'd1);
    step_bad = ((phase ^ phase_prev_reg) == 2'b11);
    acc_next = acc_reg;
    if (step_cw && acc_reg != ACC_FULL) begin
      acc_next = acc_reg + 4'sd1;
    end else if (step_ccw && acc_reg != -ACC_FULL) begin
      acc_next = acc_reg - 4'sd1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      phase_prev_reg <= PH_DETENT;
      acc_reg        <= '0;
      event_reg      <= 1'b0;
      right_reg      <= 1'b0;
    end else begin
      phase_prev_reg <= phase;
      event_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (step_bad) begin
            state_reg <= ST_RESYNC;
          end else if (step_cw || step_ccw) begin
            acc_reg   <= acc_next;
            state_reg <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (step_bad) begin
            acc_reg   <= '0;
            state_reg <= ST_RESYNC;
          end else if (phase == PH_DETENT && (step_cw || step_ccw)) begin
            // Only a full saturated swing counts; anything else was a partial turn.
            if (acc_next == ACC_FULL) begin
              event_reg <= 1'b1;
              right_reg <= 1'b1;
            end else if (acc_next == -ACC_FULL) begin
              event_reg <= 1'b1;
              right_reg <= 1'b0;
            end
            acc_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            acc_reg <= acc_next;
          end
        end
        ST_RESYNC: begin
          acc_reg <= '0;
          if (phase == PH_DETENT) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          acc_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign rotary_event = event_reg;
  assign rotary_right = right_reg;

`ifdef ROTARY_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err_cnt_reg <= 8'd0;
    end else if (step_bad && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_count = err_cnt_reg;
`endif

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder with FILTER_CYCLES=4: clean turns both ways,
// bounce, partial turn, invalid step and asynchronous reset mid-rotation.
module tb_rotary_decoder;

  localparam int          FW = 16;
  localparam logic [15:0] FC = 16'd4;

  logic CLK = 1'b0;
  logic reset;
  logic rotary_a;
  logic rotary_b;
  logic rotary_event;
  logic rotary_right;
`ifdef ROTARY_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;
  int ev_cnt   = 0;
  int base;

  rotary_decoder #(
    .FILTER_W      (FW),
    .FILTER_CYCLES (FC)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .rotary_a     (rotary_a),
    .rotary_b     (rotary_b),
    .rotary_event (rotary_event),
    .rotary_right (rotary_right)
`ifdef ROTARY_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (rotary_event === 1'b1) ev_cnt++;
  end

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Drive phase {A,B} on a falling edge and hold it for the given number of cycles.
  task set_ab(input logic [1:0] p, input int hold);
    {rotary_a, rotary_b} = p;
    repeat (hold) @(negedge CLK);
  endtask

  task detent_cw();
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    set_ab(2'b10, 10);
    set_ab(2'b11, 14);
  endtask

  initial begin
    reset    = 1'b1;
    rotary_a = 1'b1;
    rotary_b = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("rst_event", rotary_event, 0);
    check("rst_right", rotary_right, 0);
`ifdef ROTARY_ERR_CNT_EN
    check("rst_err", err_count, 0);
`endif

    // Clockwise detent; event must appear exactly 7 cycles after the final 11.
    base = ev_cnt;
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    set_ab(2'b10, 10);
    set_ab(2'b11, 6);
    check("cw_early", rotary_event, 0);
    @(negedge CLK);
    check("cw_pulse", rotary_event, 1);
    check("cw_right", rotary_right, 1);
    @(negedge CLK);
    check("cw_width", rotary_event, 0);
    repeat (6) @(negedge CLK);
    check("cw_count", ev_cnt - base, 1);

    // Counter-clockwise detent; direction must stay 0 afterwards.
    base = ev_cnt;
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
    set_ab(2'b01, 10);
    set_ab(2'b11, 14);
    check("ccw_count", ev_cnt - base, 1);
    check("ccw_right", rotary_right, 0);
    repeat (20) @(negedge CLK);
    check("ccw_right_hold", rotary_right, 0);

    // Contact A bounces with 2-cycle pulses before settling low.
    base = ev_cnt;
    set_ab(2'b01, 2);
    set_ab(2'b11, 2);
    set_ab(2'b01, 2);
    set_ab(2'b11, 2);
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    set_ab(2'b10, 10);
    set_ab(2'b11, 14);
    check("bounce_count", ev_cnt - base, 1);
    check("bounce_right", rotary_right, 1);

    // Partial turn that backs out to the detent.
    base = ev_cnt;
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    set_ab(2'b01, 10);
    set_ab(2'b11, 14);
    check("partial_none", ev_cnt - base, 0);
    detent_cw();
    check("partial_next", ev_cnt - base, 1);

    // Reversal mid-detent after a counter-clockwise event.
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
    set_ab(2'b01, 10);
    set_ab(2'b11, 14);
    base = ev_cnt;
    set_ab(2'b01, 10);
    set_ab(2'b11, 14);
    check("reverse_none", ev_cnt - base, 0);
    check("reverse_right", rotary_right, 0);

    // Invalid double-bit step, then resume after returning to the detent.
    base = ev_cnt;
    set_ab(2'b00, 10);
`ifdef ROTARY_ERR_CNT_EN
    check("inv_err", err_count, 1);
`endif
    set_ab(2'b10, 10);
    set_ab(2'b11, 14);
    check("inv_none", ev_cnt - base, 0);
    detent_cw();
    check("inv_resume", ev_cnt - base, 1);
    check("inv_right", rotary_right, 1);
`ifdef ROTARY_ERR_CNT_EN
    check("inv_err_hold", err_count, 1);
`endif

    // Asynchronous reset while parked at phase 00 mid-rotation.
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    #2 reset = 1'b1;
    #1;
    check("arst_event", rotary_event, 0);
    check("arst_right", rotary_right, 0);
`ifdef ROTARY_ERR_CNT_EN
    check("arst_err", err_count, 0);
`endif
    @(negedge CLK);
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    base = ev_cnt;
    set_ab(2'b00, 10);
    set_ab(2'b10, 10);
    set_ab(2'b11, 14);
    check("arst_none", ev_cnt - base, 0);
    detent_cw();
    check("arst_resume", ev_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
